sigmoid_rr_sched: RTL and testbench
===================================

# sigmoid_rr_sched

Round-robin scheduler that shares one pipelined 8-bit sigmoid datapath between NREQ requesters. It accepts one sample per cycle from the winning requester and pushes the sample through a three-register pipeline: capture, then step1 plus square, then step2. It returns each 10-bit result tagged with the requester index. It sits between the neuron-layer input queues and the activation write-back path, and supports output backpressure.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), width of the requester tag
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester sample valid
- req_x  input  NREQ*8  signed samples; requester i uses bits [8i+7:8i]
- req_ready  output  NREQ  one-hot grant; a sample is accepted when req_valid[i] and req_ready[i] are both high at a clock edge
- out_valid  output  1  result valid
- out_data  output  10  sigmoid result
- out_id  output  IDW  index of the requester that produced the result
- out_ready  input  1  downstream accepts the result
- busy  output  1  any pipeline stage holds a valid entry

## Operation
- Arbitration:
  - Round-robin over requesters with req_valid high, starting from (last_grant+1) mod NREQ.
  - last_grant updates only on an accept.
  - Reset value of last_grant is NREQ-1, so requester 0 has highest priority first.
- req_ready:
  - Combinational: one-hot on the selected requester when the pipeline can advance, otherwise all zero.
  - Forced to zero while rst_n is low.
  - May depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Datapath, all arithmetic signed:
  - y = |x| in 8 bits (x = -128 gives y = -128).
  - z = y >>> 2.
  - If x < 0: s = (x > -64) ? 8'hF0 + z : 0.
  - If x >= 0: s = (x < 63) ? 8'h10 - z : 1.
  - sq = s*s, 16-bit. t = sq >>> 1.
  - out_data = x < 0 ? t[9:0] : (16'h0100 - t)[9:0].
- Stages:
  - S0 registers {x, id, v}.
  - S1 registers {x, sq, id, v}.
  - S2 is the output register {out_data, out_id, out_valid}.
- Stall:
  - stall = out_valid & ~out_ready.
  - During a stall, all stages hold their contents and req_ready is zero.
  - When not stalled, every stage advances each cycle. Bubbles (v = 0) propagate.
- busy = S0.v | S1.v | out_valid.
- Results leave in acceptance order. No entry is dropped or duplicated.

## Timing
- Latency: a sample accepted at edge E appears on out_valid/out_data/out_id after edge E+2, with no stall.
- Throughput: one result per cycle with out_ready held high.
- Output holds: out_valid, out_data and out_id stay stable while out_valid is high and out_ready is low.
- Same-edge accept and drain: out_ready high with out_valid high at edge E retires the result. A new accept at E is allowed in the same cycle.
- Reset values: out_valid 0, out_data 0, out_id 0, busy 0, all stage valids 0, last_grant NREQ-1.
- Reset mid-operation: in-flight entries are discarded with no output. After rst_n rises, the first grant goes to the lowest-index requester with req_valid high.
- Persistent requester: if a requester keeps req_valid high but loses arbitration, it is granted within NREQ accepts.

## Structure
- Shared package sigmoid_pkg holds:
  - Constants XW=8, SQW=16, OW=10.
  - Constants ONE_Q=16'h0100, S_POS=8'h10, S_NEG=8'hF0.
  - The saturation thresholds -64 and 63.
  - A stage struct type {x, sq, id, v}.
- One sub-module, sigmoid_pipe: the S0–S2 datapath with a stall input.
- The top level holds only the arbiter and the pointer.

## Test plan
- Reset: hold rst_n low with all req_valid high -> req_ready = 0, out_valid = 0, busy = 0.
- Single sample, requester 2, x = 0, accepted at edge E -> out_valid after E+2 with out_data = 128, out_id = 2, then busy = 0.
- Values through requester 0:
  - x = 32 -> out_data = 224.
  - x = -32 -> out_data = 32.
  - x = 100 -> out_data = 256.
  - x = -100 -> out_data = 0.
  - x = -128 -> out_data = 0.
  - x = 62 -> s = 1, out_data = 256.
- Fairness: NREQ = 4, all req_valid held high for 8 accepts -> grant order 0,1,2,3,0,1,2,3, and out_id follows the same order.
- Backpressure: stream 5 samples, drop out_ready for 3 cycles in the middle -> outputs stable during the stall, req_ready = 0 during the stall, all 5 results delivered in order.
- Mid-stream reset: pulse rst_n low with 3 entries in flight -> none of them emitted. After release, requester 1 alone valid -> granted first cycle.

Source files
------------

// File: rtl/sigmoid_pkg.sv
// rtl/sigmoid_pkg.sv - shared constants, stage type and slope helper for the sigmoid scheduler
package sigmoid_pkg;
  localparam int XW      = 8;
  localparam int SQW     = 16;
  localparam int OW      = 10;
  localparam int IDW_MAX = 3;

  localparam logic signed [SQW-1:0] ONE_Q     = 16'sh0100;
  localparam logic signed [XW-1:0]  S_POS     = 8'sh10;
  localparam logic signed [XW-1:0]  S_NEG     = 8'shF0;
  localparam logic signed [XW-1:0]  X_NEG_SAT = -8'sd64;
  localparam logic signed [XW-1:0]  X_POS_SAT = 8'sd63;

  typedef struct packed {
    logic signed [XW-1:0]  x;
    logic signed [SQW-1:0] sq;
    logic [IDW_MAX-1:0]    id;
    logic                  v;
  } stage_t;

  // Piecewise slope term; saturates to 0 (negative side) or 1 (positive side).
  function automatic logic signed [XW-1:0] sig_slope(input logic signed [XW-1:0] x);
    logic signed [XW-1:0] y;
    logic signed [XW-1:0] z;
    y = x[XW-1] ? -x : x;
    z = y >>> 2;
    if (x[XW-1]) sig_slope = (x > X_NEG_SAT) ? S_NEG + z : '0;
    else         sig_slope = (x < X_POS_SAT) ? S_POS - z : 8'sd1;
  endfunction
endpackage

// File: rtl/sigmoid_pipe.sv
// rtl/sigmoid_pipe.sv - three-register sigmoid datapath with a global stall
module sigmoid_pipe
  import sigmoid_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 in_valid,
  input  logic signed [XW-1:0] in_x,
  input  logic [IDW_MAX-1:0]   in_id,
  output logic                 out_valid,
  output logic [OW-1:0]        out_data,
  output logic [IDW_MAX-1:0]   out_id,
  output logic                 busy
);
  logic                  s0_v;
  logic signed [XW-1:0]  s0_x;
  logic [IDW_MAX-1:0]    s0_id;
  stage_t                s1;

  logic signed [XW-1:0]  s_val;
  logic signed [SQW-1:0] s_ext;
  logic signed [SQW-1:0] sq_next;
  logic signed [SQW-1:0] t;
  logic signed [SQW-1:0] diff;
  logic [OW-1:0]         res_next;
  logic                  unused_msbs;

  always_comb begin
    s_val    = sig_slope(s0_x);
    s_ext    = {{(SQW-XW){s_val[XW-1]}}, s_val};
    sq_next  = s_ext * s_ext;
    t        = s1.sq >>> 1;
    diff     = ONE_Q - t;
    res_next = s1.x[XW-1] ? t[OW-1:0] : diff[OW-1:0];
  end

  assign unused_msbs = ^{t[SQW-1:OW], diff[SQW-1:OW]};

  // Bubbles advance like real entries; only a stalled output freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v      <= 1'b0;
      s0_x      <= '0;
      s0_id     <= '0;
      s1        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (!stall) begin
      s0_v      <= in_valid;
      s0_x      <= in_x;
      s0_id     <= in_id;
      s1        <= '{x: s0_x, sq: sq_next, id: s0_id, v: s0_v};
      out_valid <= s1.v;
      out_data  <= res_next;
      out_id    <= s1.id;
    end
  end

  assign busy = s0_v | s1.v | out_valid;
endmodule

// File: rtl/sigmoid_rr_sched.sv
// rtl/sigmoid_rr_sched.sv - round-robin arbiter feeding one shared sigmoid pipeline
module sigmoid_rr_sched
  import sigmoid_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*8-1:0] req_x,
  output logic [NREQ-1:0]  req_ready,
  output logic             out_valid,
  output logic [OW-1:0]    out_data,
  output logic [IDW-1:0]   out_id,
  input  logic             out_ready,
  output logic             busy
);
  logic [IDW-1:0]       last_grant;
  logic [IDW-1:0]       sel_id;
  logic [IDW:0]         cand;
  logic                 sel_found;
  logic                 stall;
  logic                 accept;
  logic signed [XW-1:0] sel_x;
  logic [IDW_MAX-1:0]   pipe_id;

  assign stall = out_valid & ~out_ready;

  // Search starts one past the last grant and wraps modulo NREQ.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_grant} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!sel_found && req_valid[cand[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_id == IDW'(i)) sel_x = req_x[i*XW +: XW];
    end
  end

  assign accept    = rst_n & ~stall & sel_found;
  assign req_ready = accept ? (NREQ'(1) << sel_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= IDW'(NREQ - 1);
    else if (accept) last_grant <= sel_id;
  end

  sigmoid_pipe u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .in_valid  (accept),
    .in_x      (sel_x),
    .in_id     (IDW_MAX'(sel_id)),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (pipe_id),
    .busy      (busy)
  );

  assign out_id = pipe_id[IDW-1:0];

  generate
    if (IDW < IDW_MAX) begin : g_id_pad
      logic unused_id_msbs;
      assign unused_id_msbs = ^pipe_id[IDW_MAX-1:IDW];
    end
  endgenerate
endmodule

// File: tb/tb_sigmoid_rr_sched.sv
// tb/tb_sigmoid_rr_sched.sv - directed self-checking bench for sigmoid_rr_sched
module tb_sigmoid_rr_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_x;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [9:0]  out_data;
  logic [1:0]  out_id;
  logic        out_ready;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [7:0] VAL_X   [6] = '{8'd32, 8'hE0, 8'd100, 8'h9C, 8'h80, 8'd62};
  localparam logic [9:0] VAL_OUT [6] = '{10'd224, 10'd32, 10'd256, 10'd0, 10'd0, 10'd256};
  localparam logic [9:0] FAIR_OUT[4] = '{10'd256, 10'd128, 10'd224, 10'd32};
  localparam logic [7:0] BP_X    [5] = '{8'd0, 8'd32, 8'hE0, 8'd100, 8'h9C};
  localparam logic [9:0] BP_OUT  [5] = '{10'd128, 10'd224, 10'd32, 10'd256, 10'd0};

  sigmoid_rr_sched #(.NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; req_x = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL reset_req_ready got %h want 0", req_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (out_data !== 10'd0) begin n_bad++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    n_cmp++; if (out_id !== 2'd0) begin n_bad++; $display("FAIL reset_out_id got %0d want 0", out_id); end
    req_valid = 4'h0; rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    req_valid = 4'b0100; req_x = '0;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_grant got %b want 0100", req_ready); end
    @(negedge clk); req_valid = 4'h0; #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL single_e1 got valid=%b busy=%b want 0/1", out_valid, busy); end
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_e2 got valid=%b want 0", out_valid); end
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 10'd128 || out_id !== 2'd2) begin
      n_bad++; $display("FAIL single_out got v=%b d=%0d id=%0d want 1/128/2", out_valid, out_data, out_id); end
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_idle got v=%b busy=%b want 0/0", out_valid, busy); end
  endtask

  task automatic test_values();
    for (int i = 0; i < 6; i++) begin
      req_valid = 4'b0001; req_x = {24'd0, VAL_X[i]};
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL value%0d_grant got %b want 0001", i, req_ready); end
      @(negedge clk); req_valid = 4'h0;
      @(negedge clk);
      @(negedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || out_data !== VAL_OUT[i] || out_id !== 2'd0) begin
        n_bad++; $display("FAIL value%0d_out got v=%b d=%0d id=%0d want 1/%0d/0", i, out_valid, out_data, out_id, VAL_OUT[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_x = {8'hE0, 8'd32, 8'd0, 8'd100};
    for (int k = 0; k < 11; k++) begin
      if (k == 0) req_valid = 4'hF;
      if (k == 8) req_valid = 4'h0;
      #1;
      if (k < 8) begin
        n_cmp++; if (req_ready !== (4'b0001 << (k % 4))) begin
          n_bad++; $display("FAIL fair_grant%0d got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
      end
      if (k >= 3) begin
        n_cmp++; if (out_valid !== 1'b1 || out_id !== 2'((k - 3) % 4) || out_data !== FAIR_OUT[(k - 3) % 4]) begin
          n_bad++; $display("FAIL fair_out%0d got v=%b id=%0d d=%0d want 1/%0d/%0d", k - 3, out_valid, out_id, out_data,
                            (k - 3) % 4, FAIR_OUT[(k - 3) % 4]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    int stalls = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      req_valid = (sent < 5) ? 4'b0001 : 4'b0000;
      req_x = (sent < 5) ? {24'd0, BP_X[sent]} : 32'd0;
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL bp_stall_ready c%0d got %b want 0", c, req_ready); end
      end else if (sent < 5) begin
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_ready c%0d got %b want 0001", c, req_ready); end
      end
      if (out_valid) begin
        n_cmp++; if (got >= 5 || out_data !== BP_OUT[got % 5] || out_id !== 2'd0) begin
          n_bad++; $display("FAIL bp_out c%0d got d=%0d id=%0d idx=%0d want d=%0d id=0", c, out_data, out_id, got, BP_OUT[got % 5]); end
        if (out_ready) got++;
      end
      if (req_valid[0] && req_ready[0]) sent++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (got !== 5) begin n_bad++; $display("FAIL bp_count got %0d want 5", got); end
    n_cmp++; if (stalls !== 3) begin n_bad++; $display("FAIL bp_stalls got %0d want 3", stalls); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_idle got busy=%b want 0", busy); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int n_out = 0;
    out_ready = 1'b0; req_valid = 4'b0001; req_x = {24'd0, 8'd32};
    repeat (3) @(negedge clk);
    req_valid = 4'h0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_inflight got v=%b busy=%b want 1/1", out_valid, busy); end
    rst_n = 1'b0; req_valid = 4'b0010; req_x = '0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'h0) begin
      n_bad++; $display("FAIL mid_flush got v=%b busy=%b rdy=%b want 0/0/0", out_valid, busy, req_ready); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL mid_first_grant got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'h0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (out_valid) begin
        n_out++;
        n_cmp++; if (out_id !== 2'd1 || out_data !== 10'd128) begin
          n_bad++; $display("FAIL mid_out got id=%0d d=%0d want 1/128", out_id, out_data); end
      end
      @(negedge clk);
    end
    n_cmp++; if (n_out !== 1) begin n_bad++; $display("FAIL mid_count got %0d want 1", n_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_values();
    test_fairness();
    test_backpressure();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
